// File: rtl/sprite_row_reader.sv
// Fetches one sprite row from synchronous RAM and streams its pixels on a valid/ready port.
// Optional SPRITE_HFLIP_EN adds an HFlip input that mirrors the row (reverse word order, MSB-first pixels).
module sprite_row_reader #(
   parameter int ADDR_W        = 10,
   parameter int PIX_W         = 3,
   parameter int PIX_PER_WORD  = 4,
   parameter int WORDS_PER_ROW = 2,
   localparam int DATA_W       = PIX_W * PIX_PER_WORD
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddr,
   output logic              Busy,
   output logic              MemRead,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic [DATA_W-1:0] MemData,
   output logic [PIX_W-1:0]  PixOut,
   output logic              PixValid,
   input  logic              PixReady,
   output logic              RowDone
`ifdef SPRITE_HFLIP_EN
   ,
   input  logic              HFlip
`endif
);

   localparam int PC_W = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
   localparam int WI_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LOAD  = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] base_reg, base_next;
   logic              flip_reg, flip_next;
   logic [WI_W-1:0]   word_reg, word_next;
   logic [PC_W-1:0]   pix_reg, pix_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic [ADDR_W-1:0] word_off, fetch_addr;
   logic              flip_in;

   logic              busy_reg, mem_read_reg, pix_valid_reg, row_done_reg;
   logic [ADDR_W-1:0] mem_addr_reg;

`ifdef SPRITE_HFLIP_EN
   assign flip_in = HFlip;
`else
   assign flip_in = 1'b0;
`endif

   always_comb begin
      state_next = state_reg;
      base_next  = base_reg;
      flip_next  = flip_reg;
      word_next  = word_reg;
      pix_next   = pix_reg;
      shift_next = shift_reg;
      case (state_reg)
         IDLE: begin
            if (Start) begin
               state_next = FETCH;
               base_next  = BaseAddr;
               flip_next  = flip_in;
               word_next  = '0;
               pix_next   = '0;
            end
         end
         FETCH: state_next = LOAD;
         LOAD: begin
            state_next = SHIFT;
            shift_next = MemData;
            pix_next   = '0;
         end
         SHIFT: begin
            if (PixReady) begin
               shift_next = flip_reg ? (shift_reg << PIX_W) : (shift_reg >> PIX_W);
               if (pix_reg == PC_W'(PIX_PER_WORD - 1)) begin
                  pix_next = '0;
                  if (word_reg == WI_W'(WORDS_PER_ROW - 1)) begin
                     state_next = DONE;
                  end else begin
                     word_next  = word_reg + 1'b1;
                     state_next = FETCH;
                  end
               end else begin
                  pix_next = pix_reg + 1'b1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A mirrored row walks the words from the top of the row downward.
   always_comb begin
      word_off   = flip_next ? (ADDR_W'(WORDS_PER_ROW - 1) - ADDR_W'(word_next))
                             : ADDR_W'(word_next);
      fetch_addr = base_next + word_off;
   end

   // Outputs are registered from the next state so they line up with state_reg.
   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_reg     <= IDLE;
         base_reg      <= '0;
         flip_reg      <= 1'b0;
         word_reg      <= '0;
         pix_reg       <= '0;
         shift_reg     <= '0;
         busy_reg      <= 1'b0;
         mem_read_reg  <= 1'b0;
         pix_valid_reg <= 1'b0;
         row_done_reg  <= 1'b0;
         mem_addr_reg  <= '0;
      end else begin
         state_reg     <= state_next;
         base_reg      <= base_next;
         flip_reg      <= flip_next;
         word_reg      <= word_next;
         pix_reg       <= pix_next;
         shift_reg     <= shift_next;
         busy_reg      <= (state_next != IDLE);
         mem_read_reg  <= (state_next == FETCH);
         pix_valid_reg <= (state_next == SHIFT);
         row_done_reg  <= (state_next == DONE);
         if (state_next == FETCH) begin
            mem_addr_reg <= fetch_addr;
         end
      end
   end

   assign Busy     = busy_reg;
   assign MemRead  = mem_read_reg;
   assign MemAddr  = mem_addr_reg;
   assign PixValid = pix_valid_reg;
   assign RowDone  = row_done_reg;
   assign PixOut   = flip_reg ? shift_reg[DATA_W-1 -: PIX_W] : shift_reg[PIX_W-1:0];

endmodule
